// File: rtl/lc3_pkg.sv
// Shared LC-3 control definitions: FSM state encoding, opcodes and mux selects.
package lc3_pkg;

    typedef enum logic [4:0] {
        StHalted,
        St18, St33, St35, St32,
        St01, St05, St09,
        St00, St22,
        St12,
        St04, St21,
        St06, St25, St27,
        St07, St23, St16,
        StPause1, StPause2
    } state_e;

    // Opcodes in IR[15:12]
    localparam logic [3:0] OpBr    = 4'b0000;
    localparam logic [3:0] OpAdd   = 4'b0001;
    localparam logic [3:0] OpJsr   = 4'b0100;
    localparam logic [3:0] OpAnd   = 4'b0101;
    localparam logic [3:0] OpLdr   = 4'b0110;
    localparam logic [3:0] OpStr   = 4'b0111;
    localparam logic [3:0] OpNot   = 4'b1001;
    localparam logic [3:0] OpJmp   = 4'b1100;
    localparam logic [3:0] OpPause = 4'b1101;

    // PCMUX: 00 = PC+1, 01 = bus, 10 = adder
    localparam logic [1:0] PcmuxInc   = 2'b00;
    localparam logic [1:0] PcmuxAdder = 2'b10;

    localparam logic [1:0] Addr2Zero   = 2'b00;
    localparam logic [1:0] Addr2Sext6  = 2'b01;
    localparam logic [1:0] Addr2Sext9  = 2'b10;
    localparam logic [1:0] Addr2Sext11 = 2'b11;

    localparam logic Addr1Pc  = 1'b0;
    localparam logic Addr1Sr1 = 1'b1;

    localparam logic [1:0] AlukAdd  = 2'b00;
    localparam logic [1:0] AlukAnd  = 2'b01;
    localparam logic [1:0] AlukNot  = 2'b10;
    localparam logic [1:0] AlukPass = 2'b11;

    localparam logic DrmuxR7    = 1'b1;
    localparam logic Sr1muxIr86 = 1'b1;

    // States that talk to memory and are stretched by the wait counter
    function automatic logic is_mem_state(input state_e s);
        return (s == St33) || (s == St25) || (s == St16);
    endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Memory wait counter: cleared when a memory state is entered, counts while
// the FSM sits in it, and pulses done_o on the last cycle of the access.
module mem_wait_ctr #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    localparam int unsigned CntW = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MEM_WAIT);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Done only while counting, so it reads as a one-cycle pulse per access
    assign done_o = en_i && (cnt_q == CntMax);

    // Next count: restart on entry, advance until the final cycle
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !done_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Count register, cleared by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lc3_control.sv
// LC-3 control unit: Moore FSM for fetch/decode/execute with stretched memory states.
module lc3_control
    import lc3_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset_ah,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        BEN,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_BEN,
    output logic        LD_CC,
    output logic        LD_REG,
    output logic        LD_PC,
    output logic        LD_LED,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic [1:0]  PCMUX,
    output logic [1:0]  ADDR2MUX,
    output logic [1:0]  ALUK,
    output logic        DRMUX,
    output logic        SR1MUX,
    output logic        SR2MUX,
    output logic        ADDR1MUX,
    output logic        MIO_EN,
    output logic        Mem_OE,
    output logic        Mem_WE
);

    state_e state_q, state_d;
    logic   sr2_q;
    logic   mem_busy, mem_load, mem_done;

    // Only the opcode and the immediate flag are decoded here
    logic unused_ir;
    assign unused_ir = ^{IR[11:6], IR[4:0]};

    assign mem_busy = is_mem_state(state_q);
    assign mem_load = is_mem_state(state_d) && (state_d != state_q);

    mem_wait_ctr #(
        .MEM_WAIT (MEM_WAIT)
    ) u_mem_wait_ctr (
        .clk_i  (Clk),
        .rst_i  (Reset_ah),
        .load_i (mem_load),
        .en_i   (mem_busy),
        .done_o (mem_done)
    );

    // State register; IR[5] is latched at decode so SR2MUX stays a pure state decode
    always_ff @(posedge Clk or posedge Reset_ah) begin
        if (Reset_ah) begin
            state_q <= StHalted;
            sr2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == St32) begin
                sr2_q <= IR[5];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHalted: if (Run) state_d = St18;
            St18:     state_d = St33;
            St33:     if (mem_done) state_d = St35;
            St35:     state_d = St32;
            St32: begin
                case (IR[15:12])
                    OpAdd:   state_d = St01;
                    OpAnd:   state_d = St05;
                    OpNot:   state_d = St09;
                    OpBr:    state_d = St00;
                    OpJmp:   state_d = St12;
                    OpJsr:   state_d = St04;
                    OpLdr:   state_d = St06;
                    OpStr:   state_d = St07;
                    OpPause: state_d = StPause1;
                    default: state_d = St18;
                endcase
            end
            St00:     state_d = BEN ? St22 : St18;
            St04:     state_d = St21;
            St06:     state_d = St25;
            St25:     if (mem_done) state_d = St27;
            St07:     state_d = St23;
            St23:     state_d = St16;
            St16:     if (mem_done) state_d = St18;
            StPause1: if (Continue) state_d = StPause2;
            StPause2: if (!Continue) state_d = St18;
            St01, St05, St09, St22, St12, St21, St27: state_d = St18;
            default:  state_d = StHalted;
        endcase
    end

    // Output decode from state only
    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = PcmuxInc;
        ADDR2MUX   = Addr2Zero;
        ALUK       = AlukAdd;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = Addr1Pc;
        MIO_EN     = 1'b0;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;
        unique case (state_q)
            St18: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
                PCMUX  = PcmuxInc;
            end
            St33, St25: begin
                Mem_OE = 1'b0;
                MIO_EN = 1'b1;
                LD_MDR = mem_done;
            end
            St35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            St32: LD_BEN = 1'b1;
            St01, St05, St09: begin
                SR1MUX  = Sr1muxIr86;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                if (state_q == St01) begin
                    ALUK   = AlukAdd;
                    SR2MUX = sr2_q;
                end else if (state_q == St05) begin
                    ALUK   = AlukAnd;
                    SR2MUX = sr2_q;
                end else begin
                    ALUK = AlukNot;
                end
            end
            St22: begin
                PCMUX    = PcmuxAdder;
                ADDR1MUX = Addr1Pc;
                ADDR2MUX = Addr2Sext9;
                LD_PC    = 1'b1;
            end
            St12: begin
                SR1MUX   = Sr1muxIr86;
                ADDR1MUX = Addr1Sr1;
                ADDR2MUX = Addr2Zero;
                PCMUX    = PcmuxAdder;
                LD_PC    = 1'b1;
            end
            St04: begin
                DRMUX  = DrmuxR7;
                GatePC = 1'b1;
                LD_REG = 1'b1;
            end
            St21: begin
                PCMUX    = PcmuxAdder;
                ADDR1MUX = Addr1Pc;
                ADDR2MUX = Addr2Sext11;
                LD_PC    = 1'b1;
            end
            St06, St07: begin
                SR1MUX     = Sr1muxIr86;
                ADDR1MUX   = Addr1Sr1;
                ADDR2MUX   = Addr2Sext6;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
            end
            St27: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            // Store data comes from IR[11:9], so SR1MUX stays 0 here
            St23: begin
                ALUK    = AlukPass;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
            end
            St16:     Mem_WE = 1'b0;
            StPause1: LD_LED = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_control.sv
// Directed bench for lc3_control: walks fetch, ADD, BR taken/not taken, STR,
// PAUSE, an unknown opcode and an asynchronous reset mid memory wait.
module tb_lc3_control;

    logic        Clk = 1'b0;
    logic        Reset_ah, Run, Continue, BEN;
    logic [15:0] IR;
    logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0]  PCMUX, ADDR2MUX, ALUK;
    logic        DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE;

    int n_checks = 0;
    int n_pass   = 0;

    // Layout: LD{MAR,MDR,IR,BEN,CC,REG,PC,LED} Gate{PC,MDR,ALU,MARMUX}
    //         PCMUX ADDR2MUX ALUK DRMUX SR1MUX SR2MUX ADDR1MUX MIO_EN Mem_OE Mem_WE
    logic [24:0] sig;
    logic [3:0]  gates;
    assign sig = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                  GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX, ALUK,
                  DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN, Mem_OE, Mem_WE};
    assign gates = {GatePC, GateMDR, GateALU, GateMARMUX};

    localparam logic [24:0] VecIdle = 25'b00000000_0000_00_00_00_0000_011;
    localparam logic [24:0] VecS18  = 25'b10000010_1000_00_00_00_0000_011;
    localparam logic [24:0] VecS33w = 25'b00000000_0000_00_00_00_0000_101;
    localparam logic [24:0] VecS33d = 25'b01000000_0000_00_00_00_0000_101;
    localparam logic [24:0] VecS35  = 25'b00100000_0100_00_00_00_0000_011;
    localparam logic [24:0] VecS32  = 25'b00010000_0000_00_00_00_0000_011;
    localparam logic [24:0] VecAdd  = 25'b00001100_0010_00_00_00_0100_011;
    localparam logic [24:0] VecS22  = 25'b00000010_0000_10_10_00_0000_011;
    localparam logic [24:0] VecS07  = 25'b10000000_0001_00_01_00_0101_011;
    localparam logic [24:0] VecS23  = 25'b01000000_0010_00_00_11_0000_011;
    localparam logic [24:0] VecS16  = 25'b00000000_0000_00_00_00_0000_010;
    localparam logic [24:0] VecP1   = 25'b00000001_0000_00_00_00_0000_011;

    lc3_control #(
        .MEM_WAIT (2)
    ) dut (
        .Clk        (Clk),
        .Reset_ah   (Reset_ah),
        .Run        (Run),
        .Continue   (Continue),
        .IR         (IR),
        .BEN        (BEN),
        .LD_MAR     (LD_MAR),
        .LD_MDR     (LD_MDR),
        .LD_IR      (LD_IR),
        .LD_BEN     (LD_BEN),
        .LD_CC      (LD_CC),
        .LD_REG     (LD_REG),
        .LD_PC      (LD_PC),
        .LD_LED     (LD_LED),
        .GatePC     (GatePC),
        .GateMDR    (GateMDR),
        .GateALU    (GateALU),
        .GateMARMUX (GateMARMUX),
        .PCMUX      (PCMUX),
        .ADDR2MUX   (ADDR2MUX),
        .ALUK       (ALUK),
        .DRMUX      (DRMUX),
        .SR1MUX     (SR1MUX),
        .SR2MUX     (SR2MUX),
        .ADDR1MUX   (ADDR1MUX),
        .MIO_EN     (MIO_EN),
        .Mem_OE     (Mem_OE),
        .Mem_WE     (Mem_WE)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Sample one cycle on the falling edge: full output vector plus gate exclusivity
    task automatic expect_state(input string tag, input logic [24:0] exp);
        @(negedge Clk);
        check(tag, {7'd0, sig}, {7'd0, exp});
        check({tag, "/gate"}, {31'd0, ($countones(gates) <= 1)}, 32'd1);
    endtask

    task automatic fetch(input string tag);
        expect_state({tag, ":S18"}, VecS18);
        expect_state({tag, ":S33a"}, VecS33w);
        expect_state({tag, ":S33b"}, VecS33w);
        expect_state({tag, ":S33c"}, VecS33d);
        expect_state({tag, ":S35"}, VecS35);
        expect_state({tag, ":S32"}, VecS32);
    endtask

    initial begin
        Reset_ah = 1'b1;
        Run      = 1'b0;
        Continue = 1'b0;
        BEN      = 1'b0;
        IR       = 16'h1283;

        expect_state("reset", VecIdle);
        Reset_ah = 1'b0;
        expect_state("halt0", VecIdle);
        expect_state("halt1", VecIdle);

        // ADD R1,R2,R3; Run left high through the instruction must be ignored
        Run = 1'b1;
        fetch("add");
        Run = 1'b0;
        expect_state("add:S01", VecAdd);

        // BRnzp taken
        IR  = 16'h0E05;
        BEN = 1'b1;
        fetch("br1");
        expect_state("br1:S00", VecIdle);
        expect_state("br1:S22", VecS22);

        // BRnzp not taken
        BEN = 1'b0;
        fetch("br0");
        expect_state("br0:S00", VecIdle);

        // STR: write held three cycles
        IR = 16'h7441;
        fetch("str");
        expect_state("str:S07", VecS07);
        expect_state("str:S23", VecS23);
        expect_state("str:S16a", VecS16);
        expect_state("str:S16b", VecS16);
        expect_state("str:S16c", VecS16);

        // PAUSE handshake
        IR = 16'hD0AA;
        fetch("pause");
        expect_state("pause:P1a", VecP1);
        Run = 1'b1;
        expect_state("pause:P1b", VecP1);
        Run      = 1'b0;
        Continue = 1'b1;
        expect_state("pause:P2a", VecIdle);
        expect_state("pause:P2b", VecIdle);
        Continue = 1'b0;

        // Unknown opcode acts as NOP
        IR = 16'hF025;
        fetch("nop");

        // Reset during the second S33 cycle must act without a clock edge
        expect_state("rst:S18", VecS18);
        expect_state("rst:S33a", VecS33w);
        expect_state("rst:S33b", VecS33w);
        #1 Reset_ah = 1'b1;
        #1 check("rst:async", {7'd0, sig}, {7'd0, VecIdle});
        expect_state("rst:held", VecIdle);
        Reset_ah = 1'b0;
        Run      = 1'b1;
        // Wait counter must restart from zero: full three-cycle S33 again
        fetch("refetch");
        Run = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lc3_control.md
LC3_CONTROL -- requirements
Module: lc3_control

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 2, meaning the number of extra cycles each memory access state is held.
REQ-002 SHALL have port Clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port Reset_ah  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port Run  input  1  start execution from Halted.
REQ-005 SHALL have port Continue  input  1  resume from PAUSE.
REQ-006 SHALL have port IR  input  16  current instruction register.
REQ-007 SHALL have port BEN  input  1  branch-enable flag from the datapath.
REQ-008 SHALL have ports LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  output  1 each  register load strobes.
REQ-009 SHALL have ports GatePC, GateMDR, GateALU, GateMARMUX  output  1 each  bus drive enables, at most one high per cycle.
REQ-010 SHALL have ports PCMUX, ADDR2MUX, ALUK  output  2 each  mux and ALU selects.
REQ-011 SHALL have ports DRMUX, SR1MUX, SR2MUX, ADDR1MUX  output  1 each  mux selects.
REQ-012 SHALL have ports MIO_EN  output  1, Mem_OE  output  1 (active-low), Mem_WE  output  1 (active-low)  memory controls.

Function
REQ-013 SHALL be a Moore FSM: outputs decode from state only; no output has a combinational input-to-output path.
REQ-014 SHALL use these encodings: PCMUX 00=PC+1, 01=bus, 10=adder; ADDR2MUX 00=0, 01=SEXT6, 10=SEXT9, 11=SEXT11; ADDR1MUX 0=PC, 1=SR1; ALUK 00=ADD, 01=AND, 10=NOT, 11=PASS; DRMUX 1=R7; SR1MUX 1=IR[8:6].
REQ-015 SHALL leave Halted only when Run=1 at a clock edge, then enter S18.
REQ-016 SHALL sequence fetch S18 (GatePC, LD_MAR, LD_PC, PCMUX=00) -> S33 (Mem_OE=0, MIO_EN=1, LD_MDR) -> S35 (GateMDR, LD_IR) -> S32 (LD_BEN, decode).
REQ-017 SHALL hold every memory state (S33, S25, S16) for MEM_WAIT+1 cycles, with LD_MDR asserted only in the final cycle and Mem_WE=0 for all cycles of S16.
REQ-018 SHALL decode IR[15:12] in S32 as: ADD 0001 -> S01; AND 0101 -> S05; NOT 1001 -> S09; BR 0000 -> S00; JMP 1100 -> S12; JSR 0100 -> S04 -> S21; LDR 0110 -> S06 -> S25 -> S27; STR 0111 -> S07 -> S23 -> S16; PAUSE 1101 -> PAUSE1.
REQ-019 SHALL drive SR2MUX = IR[5] in S01 and S05, and assert LD_CC in S01, S05, S09 and S27.
REQ-020 SHALL go S00 -> S22 when BEN=1 and S00 -> S18 when BEN=0.
REQ-021 SHALL treat any other opcode as a NOP and return S32 -> S18.
REQ-022 SHALL assert LD_LED in PAUSE1, stay in PAUSE1 while Continue=0, go to PAUSE2 when Continue=1, stay in PAUSE2 while Continue=1, and go to S18 when Continue=0.
REQ-023 SHALL return every terminal execute state to S18 on the next edge.
REQ-024 SHALL ignore Run outside Halted.

Reset
REQ-025 SHALL, on Reset_ah=1 at any time including mid-instruction or mid-wait, enter Halted immediately, clear the wait counter, force all strobes, gates and selects to 0, and force Mem_OE=Mem_WE=1.

Structure
REQ-026 SHALL take the state enum, opcode constants and mux encodings from the shared package lc3_pkg.
REQ-027 SHALL implement the memory wait in the sub-module mem_wait_ctr: load on entering a memory state, give a done pulse when the count reaches MEM_WAIT.

Verification
REQ-028 SHALL cover reset release then Run=1: S18, S33 x3 (MEM_WAIT=2), S35, S32, with only GatePC high in S18.
REQ-029 SHALL cover IR=x1283 (ADD R1,R2,R3): S01 with SR2MUX=0, SR1MUX=1, ALUK=00, LD_REG=1, LD_CC=1, then back to S18.
REQ-030 SHALL cover IR=x0E05 (BRnzp) with BEN=1 -> S22 PCMUX=10, ADDR2MUX=10; with BEN=0 -> S18 directly.
REQ-031 SHALL cover IR=x7441 (STR): S07 -> S23 -> S16 with Mem_WE=0 for 3 cycles and never more than one Gate high.
REQ-032 SHALL cover IR=xD0AA (PAUSE): LD_LED=1, hold until Continue=1 then 0, then resume at S18.
REQ-033 SHALL cover Reset_ah asserted during the second S33 cycle: Halted plus all REQ-025 outputs without waiting for a clock edge.
